dram_mem_tester: RTL and testbench

//  Initiator for the DRAM user-side interface: drives ren/wen/addr/data/mask, honours busy,

---
 rtl/dram_mem_tester.sv | 169 ++++++++++++++++
 tb/tb_dram_mem_tester.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_mem_tester.sv
// DRAM user-side memory tester: writes a deterministic pattern, reads it back and compares.
// Optional macro DRAM_TESTER_INVERT_PASS_EN adds a second pass with the inverted pattern.
module dram_mem_tester #(
    parameter int          ADDR_WIDTH      = 27,
    parameter int          DATA_WIDTH      = 128,
    parameter int          MASK_WIDTH      = 16,
    parameter int          ADDR_STEP       = 8,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] SEED            = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_num_words,
    output logic                  o_dram_ren,
    output logic                  o_dram_wen,
    output logic [ADDR_WIDTH-1:0] o_dram_addr,
    output logic [DATA_WIDTH-1:0] o_dram_data,
    output logic [MASK_WIDTH-1:0] o_dram_mask,
    output logic                  o_dram_rready,
    input  logic                  i_dram_calib_done,
    input  logic                  i_dram_busy,
    input  logic [DATA_WIDTH-1:0] i_dram_data,
    input  logic                  i_dram_data_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [15:0]           o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);
    localparam int                    OW    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int                    LANES = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [OW-1:0]         MAXO  = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, CAL, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base_q, num_q, wr_idx, rd_iss_idx, rd_idx;
    logic [OW-1:0]         outstanding;
    logic                  first_seen;
    logic                  inv;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] k,
                                                      input logic invert);
        logic [DATA_WIDTH-1:0] p;
        logic [31:0]           k32;
        k32 = 32'(k);
        for (int j = 0; j < LANES; j++)
            p[j*32 +: 32] = (k32 + 32'(j)) ^ SEED;
        return invert ? ~p : p;
    endfunction

    logic start_ok, last_wr, last_rd, rd_valid, mismatch;
    assign start_ok = i_start && (state == IDLE || state == DONE);
    assign last_wr  = o_dram_wen && (wr_idx == num_q - 1'b1);
    assign last_rd  = o_dram_ren && (rd_iss_idx == num_q - 1'b1);
    assign rd_valid = i_dram_data_valid && (state == READ || state == DRAIN);
    assign mismatch = rd_valid && (i_dram_data != pattern(rd_idx, inv));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:  if (i_start) state_next = CAL;
            CAL:   if (i_dram_calib_done) state_next = (num_q == '0) ? DONE : WRITE;
            WRITE: if (last_wr) state_next = READ;
            READ:  if (last_rd) state_next = DRAIN;
`ifdef DRAM_TESTER_INVERT_PASS_EN
            DRAIN: if (outstanding == '0) state_next = inv ? DONE : WRITE;
`else
            DRAIN: if (outstanding == '0) state_next = DONE;
`endif
            DONE:  if (i_start) state_next = CAL;
            default: state_next = IDLE;
        endcase
    end

    // Commands are combinational so a busy-free cycle is accepted in that same cycle.
    always_comb begin
        o_dram_wen  = (state == WRITE) && !i_dram_busy;
        o_dram_ren  = (state == READ) && !i_dram_busy && (outstanding < MAXO);
        o_dram_addr = '0;
        o_dram_data = '0;
        if (o_dram_wen) begin
            o_dram_addr = base_q + wr_idx * STEP;
            o_dram_data = pattern(wr_idx, inv);
        end else if (o_dram_ren) begin
            o_dram_addr = base_q + rd_iss_idx * STEP;
        end
    end

    assign o_dram_mask   = '0;
    assign o_dram_rready = 1'b1;
    assign o_busy        = (state != IDLE) && (state != DONE);

`ifdef DRAM_TESTER_INVERT_PASS_EN
    logic restart;
    assign restart = (state == DRAIN) && (outstanding == '0) && !inv;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           inv <= 1'b0;
        else if (start_ok) inv <= 1'b0;
        else if (restart)  inv <= 1'b1;
    end
`else
    logic restart;
    assign restart = 1'b0;
    assign inv     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q           <= '0;
            num_q            <= '0;
            wr_idx           <= '0;
            rd_iss_idx       <= '0;
            rd_idx           <= '0;
            outstanding      <= '0;
            first_seen       <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else if (start_ok) begin
            base_q           <= i_base_addr;
            num_q            <= i_num_words;
            wr_idx           <= '0;
            rd_iss_idx       <= '0;
            rd_idx           <= '0;
            first_seen       <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else begin
            if (restart) begin
                wr_idx     <= '0;
                rd_iss_idx <= '0;
                rd_idx     <= '0;
            end else begin
                if (o_dram_wen) wr_idx <= wr_idx + 1'b1;
                if (o_dram_ren) rd_iss_idx <= rd_iss_idx + 1'b1;
                if (rd_valid)   rd_idx <= rd_idx + 1'b1;
            end
            if (o_dram_ren && !(rd_valid && outstanding != '0))
                outstanding <= outstanding + 1'b1;
            else if (!o_dram_ren && rd_valid && outstanding != '0)
                outstanding <= outstanding - 1'b1;
            if (mismatch) begin
                if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
                if (!first_seen) begin
                    first_seen       <= 1'b1;
                    o_first_err_addr <= base_q + rd_idx * STEP;
                end
            end
            if (state_next == DONE && state != DONE) begin
                o_done <= 1'b1;
                o_pass <= (o_err_count == '0) && !mismatch;
            end
        end
    end
endmodule

// File: tb/tb_dram_mem_tester.sv
// Directed bench for dram_mem_tester with a small in-order DRAM model (latency, busy, bit flips).
module tb_dram_mem_tester;
    logic         clk = 0, rst = 1;
    logic         i_start = 0;
    logic [26:0]  i_base_addr = 0, i_num_words = 0;
    logic         o_dram_ren, o_dram_wen, o_dram_rready;
    logic [26:0]  o_dram_addr, o_first_err_addr;
    logic [127:0] o_dram_data, i_dram_data = 0;
    logic [15:0]  o_dram_mask, o_err_count;
    logic         i_dram_calib_done = 0, i_dram_busy = 0, i_dram_data_valid = 0;
    logic         o_busy, o_done, o_pass;

    dram_mem_tester dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_words(i_num_words), .o_dram_ren(o_dram_ren), .o_dram_wen(o_dram_wen),
        .o_dram_addr(o_dram_addr), .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask),
        .o_dram_rready(o_dram_rready), .i_dram_calib_done(i_dram_calib_done),
        .i_dram_busy(i_dram_busy), .i_dram_data(i_dram_data),
        .i_dram_data_valid(i_dram_data_valid), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(k + j);
        return r;
    endfunction

    // DRAM model state
    typedef struct { logic [26:0] addr; int t; } rd_t;
    rd_t          q[$];
    logic [127:0] mem [logic [26:0]];
    int           cyc = 0, latency = 1;
    bit           busy_toggle = 0, flip_en = 0;
    logic [26:0]  flip_a0, flip_a1, exp_base;
    int           wr_cnt, rd_cnt, rd_ret, outst, max_out, both, wr_bad, rd_bad;
    int           wr_last_cyc, first_rd_cyc;
    logic [26:0]  wr_addrs[$];

    task automatic clear_model();
        mem.delete(); wr_addrs.delete();
        wr_cnt = 0; rd_cnt = 0; rd_ret = 0; outst = 0; max_out = 0; both = 0;
        wr_bad = 0; rd_bad = 0; wr_last_cyc = 0; first_rd_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            i_dram_data_valid = 0;
            i_dram_busy = 0;
        end else begin
            i_dram_data_valid = 0;
            if (q.size() > 0 && q[0].t <= cyc) begin
                rd_t it;
                it = q.pop_front();
                i_dram_data = mem.exists(it.addr) ? mem[it.addr] : '0;
                if (flip_en && (it.addr == flip_a0 || it.addr == flip_a1)) i_dram_data[0] = ~i_dram_data[0];
                i_dram_data_valid = 1;
                rd_ret++; outst--;
            end
            i_dram_busy = busy_toggle ? ~i_dram_busy : 1'b0;
            #1;
            if (o_dram_ren && o_dram_wen) both++;
            if (o_dram_wen) begin
                mem[o_dram_addr] = o_dram_data;
                wr_addrs.push_back(o_dram_addr);
                if (o_dram_addr != exp_base + 27'(wr_cnt * 8) || o_dram_data != pat(wr_cnt)) wr_bad++;
                wr_cnt++; wr_last_cyc = cyc;
            end
            if (o_dram_ren) begin
                q.push_back('{addr: o_dram_addr, t: cyc + latency});
                if (o_dram_addr != exp_base + 27'(rd_cnt * 8)) rd_bad++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_cnt++; outst++;
                if (outst > max_out) max_out = outst;
            end
        end
        cyc++;
    end

    task automatic start_test(input logic [26:0] base, input logic [26:0] num);
        @(negedge clk);
        clear_model();
        exp_base = base;
        i_base_addr = base; i_num_words = num; i_start = 1;
        @(negedge clk);
        i_start = 0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!o_done && cycles < budget) begin
            @(posedge clk); #1; cycles++;
        end
        check("done_reached", o_done, 1);
    endtask

    int n;

    initial begin
        // 1: reset values, calibration gating, basic 4-word run
        repeat (3) @(negedge clk);
        #1;
        check("rst_rready", o_dram_rready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cmds", {o_dram_ren, o_dram_wen}, 0);
        check("rst_addr", o_dram_addr, 0);
        rst = 0;
        start_test(27'h0, 27'd4);
        repeat (10) @(negedge clk);
        check("cal_no_cmds", wr_cnt + rd_cnt, 0);
        check("cal_busy", o_busy, 1);
        i_dram_calib_done = 1;
        wait_done(200, n);
        check("t1_wr_cnt", wr_cnt, 4);
        check("t1_wa0", wr_addrs[0], 27'h0);
        check("t1_wa1", wr_addrs[1], 27'h8);
        check("t1_wa2", wr_addrs[2], 27'h10);
        check("t1_wa3", wr_addrs[3], 27'h18);
        check("t1_wr_data", wr_bad, 0);
        check("t1_rd_cnt", rd_cnt, 4);
        check("t1_rd_after_wr", first_rd_cyc > wr_last_cyc, 1);
        check("t1_pass", o_pass, 1);
        check("t1_err", o_err_count, 0);
        check("t1_busy_end", o_busy, 0);

        // 2: busy toggling each cycle
        busy_toggle = 1;
        start_test(27'h40, 27'd8);
        check("t2_done_clr", o_done, 0);
        wait_done(400, n);
        busy_toggle = 0;
        check("t2_wr_cnt", wr_cnt, 8);
        check("t2_wr_seq", wr_bad, 0);
        check("t2_rd_seq", rd_bad, 0);
        check("t2_pass", o_pass, 1);

        // 3: long read latency, outstanding limit
        latency = 40;
        start_test(27'h0, 27'd32);
        wait_done(2000, n);
        latency = 1;
        check("t3_max_out_le8", max_out <= 8, 1);
        check("t3_max_out_hit8", max_out, 8);
        check("t3_rd_ret", rd_ret, 32);
        check("t3_pass", o_pass, 1);
        check("t3_err", o_err_count, 0);

        // 4: bit flips on words 5 and 9
        flip_en = 1; flip_a0 = 27'h128; flip_a1 = 27'h148;
        start_test(27'h100, 27'd16);
        wait_done(400, n);
        flip_en = 0;
        check("t4_pass", o_pass, 0);
        check("t4_err", o_err_count, 2);
        check("t4_first", o_first_err_addr, 27'h128);

        // 5: zero-length test (calib already high)
        start_test(27'h0, 27'd0);
        check("t5_err_clr", o_err_count, 0);
        wait_done(3, n);
        check("t5_pass", o_pass, 1);
        check("t5_no_cmds", wr_cnt + rd_cnt, 0);

        // 6: reset mid-READ, then a clean rerun
        latency = 5;
        start_test(27'h200, 27'd64);
        n = 0;
        while (rd_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        check("t6_in_read", rd_cnt >= 3, 1);
        #2 rst = 1;
        #1;
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_cmds", {o_dram_ren, o_dram_wen}, 0);
        check("t6_rst_done", o_done, 0);
        check("t6_rst_rready", o_dram_rready, 1);
        @(negedge clk); @(negedge clk);
        rst = 0;
        latency = 1;
        start_test(27'h7FFFFF0, 27'd4);
        wait_done(200, n);
        check("t6_wrap_seq", wr_bad + rd_bad, 0);
        check("t6_pass", o_pass, 1);
        check("t6_err", o_err_count, 0);
        check("never_both", both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
